// File: rtl/serial_add_sub_pkg.sv
// serial_add_sub_pkg
//   Shared definitions for the bit-serial adder/subtractor: default datapath
//   width and the controller state encoding.
//   No ports.
package serial_add_sub_pkg;

    localparam int DATA_WIDTH       = 32;
    localparam int DATA_INDEX_LIMIT = DATA_WIDTH - 1;

    typedef enum logic [1:0] {
        SAS_IDLE = 2'b00,
        SAS_BUSY = 2'b01,
        SAS_DONE = 2'b10
    } sas_state_e;

endpackage : serial_add_sub_pkg

// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if
//   Request/result bundle between the ALU/control unit (master) and the
//   bit-serial adder/subtractor (slave).
//   Signals:
//     START  request, sampled by the slave in IDLE or DONE
//     SnA    0 = add, 1 = subtract (sampled with START)
//     A, B   operands (sampled with START)
//     Y      result, valid from DONE until the next accepted START
//     CO     carry out of the MSB (subtract: 1 = no borrow)
//     OVF    signed overflow
//     BUSY   high while bits are being processed
//     DONE   one-cycle completion pulse
interface serial_add_sub_if
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
);

    logic             START;
    logic             SnA;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Y;
    logic             CO;
    logic             OVF;
    logic             BUSY;
    logic             DONE;

    modport master (
        output START, SnA, A, B,
        input  Y, CO, OVF, BUSY, DONE
    );

    modport slave (
        input  START, SnA, A, B,
        output Y, CO, OVF, BUSY, DONE
    );

endinterface : serial_add_sub_if

// File: rtl/serial_add_sub_full_adder.sv
// serial_add_sub_full_adder
//   Team 1-bit full-adder cell.
//   Ports:
//     A, B, CI  in   addend bits and carry in
//     S         out  sum bit
//     CO        out  carry out
module serial_add_sub_full_adder (
    output logic S,
    output logic CO,
    input  logic A,
    input  logic B,
    input  logic CI
);

    assign S  = A ^ B ^ CI;
    assign CO = (A & B) | (A & CI) | (B & CI);

endmodule : serial_add_sub_full_adder

// File: rtl/serial_add_sub.sv
// serial_add_sub
//   Bit-serial WIDTH-bit adder/subtractor: one full-adder cell plus a carry
//   flop, one bit per clock, LSB first. START loads the operands; WIDTH
//   cycles later DONE pulses with Y/CO/OVF valid. START in the DONE cycle
//   reloads immediately (back-to-back); START while busy is ignored.
//   Ports:
//     CLK   in   clock, posedge
//     RST   in   asynchronous active-low reset
//     bus   slave modport of serial_add_sub_if (START/SnA/A/B in,
//           Y/CO/OVF/BUSY/DONE out)
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input logic           CLK,
    input logic           RST,
    serial_add_sub_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    sas_state_e       state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             carry_q, carry_d;
    logic             msb_cin_q, msb_cin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic fa_s;
    logic fa_co;

    serial_add_sub_full_adder u_fa (
        .S  (fa_s),
        .CO (fa_co),
        .A  (ra_q[0]),
        .B  (rb_q[0]),
        .CI (carry_q)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= SAS_IDLE;
            ra_q      <= '0;
            rb_q      <= '0;
            y_q       <= '0;
            carry_q   <= 1'b0;
            msb_cin_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            y_q       <= y_d;
            carry_q   <= carry_d;
            msb_cin_q <= msb_cin_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        y_d       = y_q;
        carry_d   = carry_q;
        msb_cin_d = msb_cin_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            SAS_IDLE, SAS_DONE: begin
                if (bus.START) begin
                    // Subtract as A + ~B + 1: invert B and seed the carry.
                    ra_d    = bus.A;
                    rb_d    = bus.B ^ {WIDTH{bus.SnA}};
                    carry_d = bus.SnA;
                    cnt_d   = '0;
                    state_d = SAS_BUSY;
                end else begin
                    state_d = SAS_IDLE;
                end
            end
            SAS_BUSY: begin
                ra_d    = ra_q >> 1;
                rb_d    = rb_q >> 1;
                y_d     = {fa_s, y_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Carry into the MSB, kept for the overflow flag.
                    msb_cin_d = carry_q;
                    state_d   = SAS_DONE;
                end
            end
            default: state_d = SAS_IDLE;
        endcase
    end

    // The carry flop holds the MSB carry-out until the next load, so CO/OVF
    // stay valid after DONE without extra storage.
    assign bus.Y    = y_q;
    assign bus.CO   = carry_q;
    assign bus.OVF  = msb_cin_q ^ carry_q;
    assign bus.BUSY = (state_q == SAS_BUSY);
    assign bus.DONE = (state_q == SAS_DONE);

endmodule : serial_add_sub

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub
//   Self-checking bench for serial_add_sub (WIDTH = 32): directed vector
//   table, randomized operations against an arithmetic reference model, and
//   hand-written sequences for back-to-back START, START while busy and
//   reset mid-operation.
module tb_serial_add_sub;

    localparam int W = 32;

    logic clk;
    logic rst_n;

    serial_add_sub_if #(.WIDTH(W)) bus ();

    serial_add_sub #(.WIDTH(W)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sna;
        logic [W-1:0] y;
        logic         co;
        logic         ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sna,
                         output logic [W-1:0] y, output logic co, output logic ovf);
        longint sa, sb, sr;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        if (sna) begin
            y  = a - b;
            co = (a >= b);
            sr = sa - sb;
        end else begin
            y  = a + b;
            co = ((longint'(a) + longint'(b)) >= 64'sh1_0000_0000);
            sr = sa + sb;
        end
        ovf = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
    endtask

    // Load on the next edge, scramble inputs afterwards, wait for DONE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sna,
                          output logic [W-1:0] y, output logic co, output logic ovf,
                          output int cyc);
        @(negedge clk);
        bus.START = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.SnA   = sna;
        @(posedge clk);
        #1;
        bus.START = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        bus.SnA   = 1'($urandom_range(0, 1));
        cyc = 0;
        while (!bus.DONE && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        y   = bus.Y;
        co  = bus.CO;
        ovf = bus.OVF;
    endtask

    initial begin
        logic [W-1:0] y, ey;
        logic         co, ovf, eco, eovf;
        int           cyc, ndone, when;
        logic [W-1:0] ra, rb;
        logic         rs;

        vecs[0] = '{a: 32'd5,          b: 32'd3,          sna: 1'b0, y: 32'h0000_0008, co: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 32'h7FFF_FFFF,  b: 32'd1,          sna: 1'b0, y: 32'h8000_0000, co: 1'b0, ovf: 1'b1};
        vecs[2] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          sna: 1'b0, y: 32'h0000_0000, co: 1'b1, ovf: 1'b0};
        vecs[3] = '{a: 32'h8000_0000,  b: 32'd1,          sna: 1'b1, y: 32'h7FFF_FFFF, co: 1'b1, ovf: 1'b1};
        vecs[4] = '{a: 32'd3,          b: 32'd5,          sna: 1'b1, y: 32'hFFFF_FFFE, co: 1'b0, ovf: 1'b0};
        vecs[5] = '{a: 32'd0,          b: 32'd0,          sna: 1'b1, y: 32'h0000_0000, co: 1'b1, ovf: 1'b0};
        vecs[6] = '{a: 32'h8000_0000,  b: 32'h8000_0000,  sna: 1'b0, y: 32'h0000_0000, co: 1'b1, ovf: 1'b1};
        vecs[7] = '{a: 32'd0,          b: 32'd1,          sna: 1'b1, y: 32'hFFFF_FFFF, co: 1'b0, ovf: 1'b0};

        rst_n     = 1'b0;
        bus.START = 1'b0;
        bus.SnA   = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        #12;
        check("reset_y",    64'(bus.Y),    64'd0);
        check("reset_co",   64'(bus.CO),   64'd0);
        check("reset_ovf",  64'(bus.OVF),  64'd0);
        check("reset_busy", 64'(bus.BUSY), 64'd0);
        check("reset_done", 64'(bus.DONE), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sna, y, co, ovf, cyc);
            check($sformatf("vec%0d_y", i),   64'(y),   64'(vecs[i].y));
            check($sformatf("vec%0d_co", i),  64'(co),  64'(vecs[i].co));
            check($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vecs[i].ovf));
            check($sformatf("vec%0d_lat", i), 64'(cyc), 64'd32);
        end

        // Results hold after DONE while idle
        repeat (3) @(posedge clk);
        #1;
        check("hold_y",    64'(bus.Y),    64'(vecs[7].y));
        check("hold_co",   64'(bus.CO),   64'(vecs[7].co));
        check("hold_done", 64'(bus.DONE), 64'd0);
        check("hold_busy", 64'(bus.BUSY), 64'd0);

        // Randomized against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = (i % 8 == 0) ? ra : W'($urandom);
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, ey, eco, eovf);
            run_op(ra, rb, rs, y, co, ovf, cyc);
            check("rand_y",   64'(y),   64'(ey));
            check("rand_co",  64'(co),  64'(eco));
            check("rand_ovf", 64'(ovf), 64'(eovf));
            check("rand_lat", 64'(cyc), 64'd32);
        end

        // Back-to-back: START held in the DONE cycle
        run_op(32'd3, 32'd5, 1'b1, y, co, ovf, cyc);
        check("b2b_first_y",  64'(y),  64'hFFFF_FFFE);
        check("b2b_first_co", 64'(co), 64'd0);
        bus.START = 1'b1;
        bus.A     = 32'd10;
        bus.B     = 32'd4;
        bus.SnA   = 1'b1;
        @(posedge clk);
        #1;
        bus.START = 1'b0;
        check("b2b_busy_after_load", 64'(bus.BUSY), 64'd1);
        cyc = 1;
        while (!bus.DONE && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("b2b_gap",   64'(cyc),    64'd33);
        check("b2b_y",     64'(bus.Y),  64'h0000_0006);
        check("b2b_co",    64'(bus.CO), 64'd1);

        // START while busy is ignored
        @(negedge clk);
        bus.START = 1'b1;
        bus.A     = 32'd1;
        bus.B     = 32'd1;
        bus.SnA   = 1'b0;
        @(posedge clk);
        #1;
        bus.START = 1'b0;
        ndone = 0;
        when  = 0;
        y     = '0;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) begin
                bus.START = 1'b1;
                bus.A     = 32'd9;
                bus.B     = 32'd9;
            end else if (i == 6) begin
                bus.START = 1'b0;
            end
            if (bus.DONE) begin
                ndone++;
                if (ndone == 1) begin
                    y    = bus.Y;
                    when = i;
                end
            end
        end
        check("ignore_y",     64'(y),     64'h0000_0002);
        check("ignore_ndone", 64'(ndone), 64'd1);
        check("ignore_lat",   64'(when),  64'd32);

        // Reset mid-operation
        @(negedge clk);
        bus.START = 1'b1;
        bus.A     = 32'h1234_5678;
        bus.B     = 32'h1111_1111;
        bus.SnA   = 1'b0;
        @(posedge clk);
        #1;
        bus.START = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_y",    64'(bus.Y),    64'd0);
        check("rst_mid_co",   64'(bus.CO),   64'd0);
        check("rst_mid_ovf",  64'(bus.OVF),  64'd0);
        check("rst_mid_busy", 64'(bus.BUSY), 64'd0);
        check("rst_mid_done", 64'(bus.DONE), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.DONE) ndone++;
        end
        check("rst_mid_no_done", 64'(ndone), 64'd0);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, y, co, ovf, cyc);
        check("rst_after_y",   64'(y),   64'h2345_6789);
        check("rst_after_co",  64'(co),  64'd0);
        check("rst_after_ovf", 64'(ovf), 64'd0);
        check("rst_after_lat", 64'(cyc), 64'd32);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_add_sub
